mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: the CPU data port (aluout/writedata/memwrite/readdata path) and a DMA/debug loader port.
- CPU has fixed priority. A streak limiter guarantees DMA progress.
- Each access completes with a one-cycle ready pulse. The CPU side holds its PC while cpu_req && !cpu_ready.

Parameters:
- AW, 8, address width
- DW, 8, data width
- RD_LAT, 1, memory read latency in cycles from issue edge to valid mem_rdata (>=1)
- MAX_STREAK, 4, maximum consecutive CPU grants while dma_req is pending (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_ready  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA side, same rules as CPU
- dma_rdata  out  DW  DMA read data, registered
- dma_ready  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- owner  out  1  granted requester (0=CPU, 1=DMA), valid when busy
- busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory.
  - WAIT: count RD_LAT cycles, reads only.
  - RESP: assert ready for a read.
- Reset: state=IDLE, owner=0, streak=0, cpu_rdata=dma_rdata=0, all ready=0, mem_en=mem_we=0.
- IDLE arbitration:
  - Only cpu_req: grant CPU.
  - Only dma_req: grant DMA.
  - Both: grant DMA if streak==MAX_STREAK, else CPU.
  - The winner is registered into owner, and the next state is ISSUE.
  - With no request, stay in IDLE.
- Streak counter:
  - On a CPU grant with dma_req high, streak+1, saturating at MAX_STREAK.
  - On a CPU grant with dma_req low, or on any DMA grant, streak=0.
- ISSUE:
  - mem_en=1; mem_we, mem_addr and mem_wdata are muxed combinationally from the owner's inputs.
  - Write: owner's ready=1 in this cycle, next state IDLE.
  - Read: next state WAIT with counter=RD_LAT-1.
- WAIT:
  - mem_en=0.
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, mem_rdata is valid. Capture it at the clock edge into the owner's rdata register, then go to RESP.
- RESP: owner's ready=1 for one cycle, next state IDLE. rdata holds until that requester's next read completes.
- Latency, with a request sampled in IDLE at cycle T:
  - Write: ready in T+1.
  - Read: ready in T+2+RD_LAT.
  - A new arbitration always passes through IDLE, so accesses are at most one per 2 cycles for writes.
- Idle drive: when mem_en=0, mem_we, mem_addr and mem_wdata are 0.
- Non-owner: ready=0, rdata unchanged.
- Protocol rule: requesters hold req/we/addr/wdata stable until ready.
  - If req drops after grant, the access still completes and ready still pulses.
  - A requester that raises req in the cycle its ready pulses starts a new arbitration in the following IDLE.
- Reset mid-operation: IDLE next cycle, no ready pulse for the abandoned access, rdata cleared. A write whose ISSUE cycle coincides with the reset edge may already have been performed by memory; this is acceptable.
- Ready pulses: cpu_ready and dma_ready are never high in the same cycle.

Test Plan:
1. CPU write only, addr 0x10 data 0xA5 → mem_en=mem_we=1, mem_addr=0x10, mem_wdata=0xA5 and cpu_ready=1 in T+1; a later CPU read of 0x10 with RD_LAT=1 → cpu_rdata=0xA5, cpu_ready in T+3.
2. DMA read only, addr 0x22, memory holds 0x3C, RD_LAT=2 → dma_ready in T+4, dma_rdata=0x3C, cpu_rdata unchanged.
3. Both requesting continuously, MAX_STREAK=4, all reads → grant order CPU,CPU,CPU,CPU,DMA,CPU…; streak returns to 0 after the DMA grant.
4. Simultaneous first requests, CPU write and DMA write, streak=0 → CPU is served first (ready T+1); DMA is granted in the next IDLE (ready T+3); memory sees both writes in that order.
5. Reset asserted during WAIT of a CPU read → next cycle busy=0, cpu_ready never pulses, cpu_rdata=0, mem_en=0.
6. CPU drops cpu_req in ISSUE of a read → access completes, cpu_ready pulses once, arbiter returns to IDLE with busy=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port synchronous data memory.
// The CPU has fixed priority. After MAX_STREAK back-to-back CPU grants with DMA waiting, DMA gets the next grant.
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] LAT_INIT   = CW'(RD_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [1:0]    state;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] streak;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          grant_dma;
  logic          done;

  // Handshake: a requester holds req/we/addr/wdata until its ready pulse.
  // Ready is high for exactly one cycle: the ISSUE cycle of a write, or the RESP cycle of a read.
  always_comb begin
    sel_we    = owner ? dma_we    : cpu_we;
    sel_addr  = owner ? dma_addr  : cpu_addr;
    sel_wdata = owner ? dma_wdata : cpu_wdata;
    mem_en    = (state == S_ISSUE);
    mem_we    = mem_en & sel_we;
    mem_addr  = mem_en ? sel_addr  : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
    done      = (mem_en & sel_we) | (state == S_RESP);
    cpu_ready = done & ~owner;
    dma_ready = done & owner;
    busy      = (state != S_IDLE);
    grant_dma = dma_req & (~cpu_req | (streak == STREAK_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      streak    <= '0;
      lat_cnt   <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || dma_req) begin
            owner <= grant_dma;
            state <= S_ISSUE;
            // The streak only grows while DMA is actually being passed over.
            if (grant_dma || !dma_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + SW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (sel_we) begin
            state <= S_IDLE;
          end else begin
            state   <= S_WAIT;
            lat_cnt <= LAT_INIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            if (owner) dma_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            state <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-requester traffic.
// A behavioural memory and an expected-response scoreboard run alongside the DUT.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RD_LAT = 2;
  localparam int MAX_STREAK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic          cpu_ready, dma_ready;
  logic          mem_en, mem_we, owner, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural memory: read data appears RD_LAT cycles after the issue edge, noise otherwise
  logic          mem_clear;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic [15:0]   wlog [$];
  assign mem_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr];
    else                   rd_pipe[0] <= DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // reference state: memory contents and each requester's last read value
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] cpu_exp_q [$];
  logic [DW-1:0] dma_exp_q [$];
  logic          owner_log [$];
  int            cpu_run = 0;

  // scoreboard monitor
  always @(negedge clk) begin
    check("ready_exclusive", {31'd0, cpu_ready & dma_ready}, 32'd0);
    if (!mem_en) check("idle_drive", {15'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    if (cpu_ready) begin
      owner_log.push_back(1'b0);
      if (cpu_exp_q.size() == 0) check("cpu_unexpected_ready", 32'd1, 32'd0);
      else check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_exp_q.pop_front()});
    end
    if (dma_ready) begin
      owner_log.push_back(1'b1);
      if (dma_exp_q.size() == 0) check("dma_unexpected_ready", 32'd1, 32'd0);
      else check("dma_rdata", {24'd0, dma_rdata}, {24'd0, dma_exp_q.pop_front()});
    end
    if (!dma_req || dma_ready) cpu_run = 0;
    else if (cpu_ready) begin
      cpu_run++;
      check("dma_starvation_bound", {31'd0, cpu_run <= MAX_STREAK + 1}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: starts just after a posedge; k = cycle offset of ready from the sampling IDLE cycle
  task automatic access(input bit who, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int k);
    bit got = 0;
    if (we) ref_mem[addr] = wdata;
    else    last_rd[who] = ref_mem[addr];
    if (who) begin
      dma_exp_q.push_back(last_rd[1]);
      dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end else begin
      cpu_exp_q.push_back(last_rd[0]);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (who ? dma_ready : cpu_ready) begin
        got = 1;
        break;
      end
      k++;
    end
    if (!got) check(who ? "dma_ready_timeout" : "cpu_ready_timeout", 32'd0, 32'd1);
    tick();
    if (who) dma_req = 1'b0;
    else     cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_ctrl", {26'd0, busy, owner, cpu_ready, dma_ready, mem_en, mem_we}, 32'd0);
    check("reset_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    tick();
  endtask

  initial begin
    int k, k2, base;
    reset = 1'b1; mem_clear = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    tick();
    mem_clear = 1'b0;
    do_reset();

    // CPU write then read of 0x10
    base = wlog.size();
    access(0, 1, 8'h10, 8'hA5, k);
    check("t1_write_latency", k, 1);
    check("t1_mem_write", (wlog.size() > base) ? {16'd0, wlog[base]} : 32'hFFFF_FFFF, 32'h10A5);
    access(0, 0, 8'h10, 8'h00, k);
    check("t1_read_latency", k, 2 + RD_LAT);
    check("t1_cpu_rdata", {24'd0, cpu_rdata}, 32'hA5);

    // DMA read of 0x22 holding 0x3C; CPU read data must stay put
    access(0, 1, 8'h22, 8'h3C, k);
    access(1, 0, 8'h22, 8'h00, k);
    check("t2_read_latency", k, 2 + RD_LAT);
    check("t2_dma_rdata", {24'd0, dma_rdata}, 32'h3C);
    check("t2_cpu_rdata_kept", {24'd0, cpu_rdata}, 32'hA5);

    // CPU drops req during ISSUE of a read
    cpu_exp_q.push_back(ref_mem[8'h22]);
    last_rd[0] = ref_mem[8'h22];
    cpu_we = 0; cpu_addr = 8'h22; cpu_req = 1;
    tick();
    cpu_req = 0;
    k = 0;
    for (int c = 0; c < 50 && !cpu_ready; c++) begin
      @(negedge clk);
      if (!cpu_ready) k++;
    end
    check("t6_ready_seen", {31'd0, cpu_ready}, 32'd1);
    tick();
    @(negedge clk);
    check("t6_idle_after", {31'd0, busy}, 32'd0);
    tick();

    // simultaneous CPU and DMA writes to one address
    do_reset();
    base = wlog.size();
    fork
      access(0, 1, 8'h40, 8'h11, k);
      access(1, 1, 8'h40, 8'h22, k2);
    join
    ref_mem[8'h40] = 8'h22;
    check("t4_cpu_latency", k, 1);
    check("t4_dma_latency", k2, 3);
    check("t4_first_write", (wlog.size() > base) ? {16'd0, wlog[base]} : 32'hFFFF_FFFF, 32'h4011);
    check("t4_second_write", (wlog.size() > base + 1) ? {16'd0, wlog[base+1]} : 32'hFFFF_FFFF, 32'h4022);

    // both requesting continuously: grant order follows the streak rule
    base = owner_log.size();
    fork
      for (int i = 0; i < 8; i++) access(0, 0, AW'($urandom_range(0, 127)), 8'h00, k);
      for (int i = 0; i < 2; i++) access(1, 0, AW'($urandom_range(128, 255)), 8'h00, k2);
    join
    begin
      int s = 0;
      bit exp_o;
      for (int i = 0; i < 10; i++) begin
        exp_o = (s == MAX_STREAK);
        s = exp_o ? 0 : s + 1;
        check("t3_grant_order",
              (owner_log.size() > base + i) ? {31'd0, owner_log[base+i]} : 32'hFFFF_FFFF,
              {31'd0, exp_o});
      end
    end

    // random traffic on disjoint address halves
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        access(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), DW'($urandom), k);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        access(1, 1'($urandom_range(0, 1)), AW'($urandom_range(128, 255)), DW'($urandom), k2);
      end
    join

    // reset during WAIT of a CPU read
    access(0, 1, 8'h10, 8'hA5, k);
    access(0, 0, 8'h10, 8'h00, k);
    check("t5_pre_rdata", {24'd0, cpu_rdata}, 32'hA5);
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", {31'd0, busy}, 32'd1);
    reset = 1; cpu_req = 0;
    @(negedge clk);
    check("t5_after_reset", {22'd0, busy, mem_en, cpu_rdata}, 32'd0);
    @(negedge clk);
    reset = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (6) tick();

    check("cpu_queue_drained", cpu_exp_q.size(), 0);
    check("dma_queue_drained", dma_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
